// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/data memory port arbiter
package mem_arb_pkg;

  // Arbiter phase: pick an owner, drive the memory, return the response
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  // Which requester owns the access currently in flight
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Starvation counter width; enough for a limit of up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory view
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of data grants that bypassed a waiting fetch
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority; increments stop once the limit is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_W'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sat = (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and data requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  owner_t        r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic w_idle;
  logic w_any_req;
  logic w_grant_if;
  logic w_sat;
  logic w_cnt_inc;
  logic w_cnt_clr;

  // Data normally wins; a fetch that has been bypassed STARVE_LIMIT times wins instead
  assign w_idle     = (r_state == ST_IDLE);
  assign w_any_req  = bus.if_req | bus.d_req;
  assign w_grant_if = bus.if_req & (~bus.d_req | w_sat);
  assign w_cnt_inc  = w_idle & bus.if_req & bus.d_req & ~w_grant_if;
  assign w_cnt_clr  = w_idle & (~bus.if_req | w_grant_if);

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_cnt_inc),
    .i_clr (w_cnt_clr),
    .o_sat (w_sat)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: one access takes exactly three cycles once started
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the winner's request fields on the grant edge; fetches never write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_idle && w_any_req) begin
      r_owner <= w_grant_if ? OWN_IF : OWN_D;
      r_we    <= w_grant_if ? 1'b0 : bus.d_we;
      r_addr  <= w_grant_if ? bus.if_addr : bus.d_addr;
      r_wdata <= w_grant_if ? '0 : bus.d_wdata;
    end
  end

  // Outputs: memory strobe only in ACCESS, owner ack and read data only in RESP
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_ack    = 1'b0;
    bus.if_rdata  = '0;
    bus.d_ack     = 1'b0;
    bus.d_rdata   = '0;
    case (r_state)
      ST_ACCESS: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = r_we;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
      end
      ST_RESP: begin
        if (r_owner == OWN_IF) begin
          bus.if_ack   = 1'b1;
          bus.if_rdata = bus.mem_rdata;
        end else begin
          bus.d_ack   = 1'b1;
          bus.d_rdata = r_we ? '0 : bus.mem_rdata;
        end
      end
      default: begin
        bus.mem_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks;
  int n_errors;

  // Transaction-level reference: one access in flight, owner chosen by the grant rules
  int          cyc;
  int          m_free;
  int          m_starve;
  int          e_acc;
  int          e_resp;
  bit          e_own_if;
  bit          e_we;
  logic [15:0] e_addr;
  logic [15:0] e_wdata;
  logic [15:0] e_rdata;
  bit          auto_drop;

  logic [15:0] mem [logic [15:0]];
  bit          ack_is_d [$];
  int          ack_cyc  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h0040;
      default: return 16'($urandom);
    endcase
  endfunction

  // Compare outputs with the reference, then play the memory and requester roles
  task automatic observe();
    bit acc;
    bit rsp;
    acc = (cyc == e_acc);
    rsp = (cyc == e_resp);
    check("mem_en",    32'(bus.mem_en),    32'(acc));
    check("mem_we",    32'(bus.mem_we),    32'(acc & e_we));
    check("mem_addr",  32'(bus.mem_addr),  acc ? 32'(e_addr) : 32'd0);
    check("mem_wdata", 32'(bus.mem_wdata), acc ? 32'(e_wdata) : 32'd0);
    check("if_ack",    32'(bus.if_ack),    32'(rsp & e_own_if));
    check("if_rdata",  32'(bus.if_rdata),  (rsp && e_own_if) ? 32'(e_rdata) : 32'd0);
    check("d_ack",     32'(bus.d_ack),     32'(rsp & ~e_own_if));
    check("d_rdata",   32'(bus.d_rdata),   (rsp && !e_own_if) ? 32'(e_rdata) : 32'd0);
    if (bus.d_ack)  begin ack_is_d.push_back(1'b1); ack_cyc.push_back(cyc); end
    if (bus.if_ack) begin ack_is_d.push_back(1'b0); ack_cyc.push_back(cyc); end
    if (acc) begin
      if (e_we) begin
        mem[e_addr]   = e_wdata;
        e_rdata       = 16'h0000;
        bus.mem_rdata = 16'($urandom);
      end else begin
        e_rdata       = mem_read(e_addr);
        bus.mem_rdata = e_rdata;
      end
    end else begin
      bus.mem_rdata = 16'($urandom);
    end
    if (rsp && auto_drop) begin
      if (e_own_if) bus.if_req = 1'b0;
      else          bus.d_req  = 1'b0;
    end
  endtask

  // Grant decision for the edge that ends the current cycle
  task automatic model_arb();
    bit g_if;
    if (cyc >= m_free) begin
      if (!bus.if_req) m_starve = 0;
      if (bus.if_req || bus.d_req) begin
        g_if = bus.if_req && (!bus.d_req || m_starve == LIMIT);
        if (g_if) m_starve = 0;
        else if (bus.if_req && m_starve < LIMIT) m_starve++;
        e_own_if = g_if;
        e_we     = g_if ? 1'b0 : bus.d_we;
        e_addr   = g_if ? bus.if_addr : bus.d_addr;
        e_wdata  = g_if ? 16'h0000 : bus.d_wdata;
        e_acc    = cyc + 1;
        e_resp   = cyc + 2;
        m_free   = cyc + 3;
      end
    end
  endtask

  task automatic tick();
    model_arb();
    @(posedge clk);
    #1;
    cyc++;
    observe();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int          a0;
  int          a1;
  bit          seen;
  logic [7:0]  order;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0;
    auto_drop = 1'b1;
    cyc = 0; m_free = 0; m_starve = 0; e_acc = -10; e_resp = -10;
    e_own_if = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    mem[16'h0040] = 16'h1234;
    mem[16'h0000] = 16'h1111;
    mem[16'hFFFF] = 16'h2222;

    repeat (2) begin @(posedge clk); #1; observe(); end
    rst = 1'b0;

    // Fetch right after reset release
    bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    idle(3);

    // Store
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'hBEEF;
    idle(3);

    // Simultaneous requests: data first, fetch three cycles later
    ack_is_d.delete(); ack_cyc.delete();
    bus.if_req = 1'b1; bus.if_addr = 16'h0200;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0300;
    idle(6);
    check("both_nack", 32'(ack_is_d.size()), 32'd2);
    if (ack_is_d.size() == 2) begin
      check("both_first_d", 32'(ack_is_d[0]), 32'd1);
      check("both_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
    end
    idle(1);

    // Both held continuously: starvation limit forces every fourth grant to fetch
    ack_is_d.delete(); ack_cyc.delete();
    auto_drop = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 16'h0044;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0500;
    idle(24);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    auto_drop = 1'b1;
    check("starve_nack", 32'(ack_is_d.size()), 32'd8);
    order = '0;
    for (int k = 0; k < 8 && k < ack_is_d.size(); k++) order = {order[6:0], ack_is_d[k]};
    check("starve_order", 32'(order), 32'hEE);
    idle(3);

    // Back-to-back loads to the address extremes
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0000;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = bus.d_ack; end
    check("b2b_ack0", 32'(seen), 32'd1);
    a0 = cyc;
    bus.d_req = 1'b1; bus.d_addr = 16'hFFFF;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = bus.d_ack; end
    check("b2b_ack1", 32'(seen), 32'd1);
    a1 = cyc;
    check("b2b_gap", 32'(a1 - a0), 32'd3);
    idle(2);

    // Reset in the middle of an access
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0600;
    tick();
    rst = 1'b1;
    #1;
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    e_acc = -10; e_resp = -10; m_starve = 0;
    @(posedge clk);
    #1;
    cyc++;
    observe();
    rst = 1'b0;
    m_free = cyc;
    idle(3);

    // Request withdrawn during ACCESS still completes
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0700;
    tick();
    bus.d_req = 1'b0;
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (!bus.if_req && $urandom_range(2) == 0) begin
        bus.if_req = 1'b1; bus.if_addr = rand_addr();
      end
      if (!bus.d_req && $urandom_range(2) == 0) begin
        bus.d_req = 1'b1; bus.d_we = 1'($urandom); bus.d_addr = rand_addr();
        bus.d_wdata = 16'($urandom);
      end
      tick();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, memory address width.
REQ-002 SHALL have parameter DW, default 16, memory data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 3, max consecutive data grants while fetch waits (range 1..15).
REQ-004 SHALL use one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 if_req  input  1  fetch request, held until if_ack.
REQ-008 if_addr  input  AW  fetch address, stable while if_req.
REQ-009 if_ack  output  1  one-cycle fetch completion pulse.
REQ-010 if_rdata  output  DW  fetch data, valid only with if_ack.
REQ-011 d_req  input  1  data request, held until d_ack.
REQ-012 d_we  input  1  1=store, 0=load, stable while d_req.
REQ-013 d_addr  input  AW  data address, stable while d_req.
REQ-014 d_wdata  input  DW  store data, stable while d_req.
REQ-015 d_ack  output  1  one-cycle data completion pulse.
REQ-016 d_rdata  output  DW  load data, valid only with d_ack.
REQ-017 mem_en  output  1  memory access strobe.
REQ-018 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-019 mem_addr  output  AW  memory address.
REQ-020 mem_wdata  output  DW  memory write data.
REQ-021 mem_rdata  input  DW  memory read data, valid the cycle after mem_en.

Function
REQ-022 SHALL implement FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS when any request is pending, ACCESS->RESP always, RESP->IDLE always.
REQ-023 In IDLE SHALL select owner: data wins over fetch unless starvation count == STARVE_LIMIT and if_req=1, then fetch wins; owner and request fields registered on the IDLE->ACCESS edge.
REQ-024 In ACCESS SHALL drive mem_en=1 and mem_we, mem_addr, mem_wdata from registered owner fields (mem_we=0, mem_wdata=0 for fetch).
REQ-025 In RESP SHALL pulse the owner's ack for exactly one cycle and drive owner rdata = mem_rdata; for stores d_rdata=0.
REQ-026 Latency: request first sampled in IDLE at edge N -> ack high in cycle N+2; throughput one access per 3 cycles.
REQ-027 Outside ACCESS, mem_en, mem_we, mem_addr, mem_wdata SHALL be 0; acks and rdata SHALL be 0 when not acked.
REQ-028 Starvation counter SHALL increment on each data grant made while if_req=1, clear on any fetch grant or when if_req=0 in IDLE, saturate at STARVE_LIMIT.
REQ-029 Simultaneous if_req and d_req with counter below limit: data granted; fetch remains pending, no ack.
REQ-030 Request dropped before its ack (protocol violation): access SHALL still complete and ack pulse anyway.
REQ-031 Request asserted during ACCESS/RESP SHALL be considered only at the next IDLE.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, counter 0, registered fields 0, all outputs 0, regardless of phase, including mid-ACCESS.
REQ-033 First arbitration after rst deassert SHALL occur in the first IDLE clock edge.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum and the owner encoding (OWN_IF, OWN_D).
REQ-035 Starvation counter SHALL be a sub-module arb_starve_cnt (inc, clr, sat output).

Verification
REQ-036 if_req=1, if_addr=0x0040, mem_rdata=0x1234 -> mem_en at cycle 1 with addr 0x0040, if_ack with if_rdata=0x1234 at cycle 2.
REQ-037 d_req=1, d_we=1, d_addr=0x0100, d_wdata=0xBEEF -> mem_en=1, mem_we=1, mem_wdata=0xBEEF in ACCESS, d_ack next cycle, d_rdata=0.
REQ-038 if_req and d_req held high continuously, STARVE_LIMIT=3 -> grant order D,D,D,IF,D,D,D,IF.
REQ-039 Both requests same cycle, counter 0 -> d_ack first, if_ack 3 cycles later.
REQ-040 rst pulsed during ACCESS -> mem_en drops same cycle, no ack issued; pending request re-arbitrated after release.
REQ-041 Back-to-back loads to 0x0000 then 0xFFFF -> acks 3 cycles apart, each rdata matches memory model.
